// File: rtl/mano_control_sequencer.sv
// -----------------------------------------------------------------------------
// mano_control_sequencer
//
// Timing and control unit of the 8-bit Mano-style computer. A sequence
// counter walks T0..T6 while the machine is running; each cycle the current
// timing state, IR and DR are decoded into the common-bus source select and
// the register / memory micro-operation strobes for the downstream datapath.
//
// Parameters
//   DATA_W  datapath / bus width (IR, DR)
//   ADDR_W  address width (AR, PC, IR address field)
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   rst      in   asynchronous active-high reset
//   start    in   one-cycle pulse; leaves idle/halt and begins fetch
//   ir       in   instruction register: [7]=I, [6:4]=opcode, [3:0]=addr/reg bits
//   dr       in   data register contents (ISZ zero test)
//   bus_sel  out  bus source: 000 none, 001 AR, 010 PC, 011 DR, 100 AC,
//                 101 IR, 111 RAM
//   ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ir, ld_ac
//            out  register load / increment strobes
//   alu_op   out  AC source when ld_ac: 00 DR, 01 AC&DR, 10 AC+DR
//   clr_ac, cma_ac, inc_ac
//            out  register-reference operations on AC
//   mem_wr   out  RAM[AR] <= bus at the clock edge
//   running  out  sequencer active
//   sc       out  current timing state index
// -----------------------------------------------------------------------------
module mano_control_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] dr,
    output logic [2:0]        bus_sel,
    output logic              ld_ar,
    output logic              inc_ar,
    output logic              ld_pc,
    output logic              inc_pc,
    output logic              ld_dr,
    output logic              inc_dr,
    output logic              ld_ir,
    output logic              ld_ac,
    output logic [1:0]        alu_op,
    output logic              clr_ac,
    output logic              cma_ac,
    output logic              inc_ac,
    output logic              mem_wr,
    output logic              running,
    output logic [2:0]        sc
);

    // Timing states; the encoding is the T index exported on sc.
    typedef enum logic [2:0] {
        T0    = 3'd0,
        T1    = 3'd1,
        T2    = 3'd2,
        T3    = 3'd3,
        T4    = 3'd4,
        T5    = 3'd5,
        T6    = 3'd6,
        T_BAD = 3'd7
    } t_state_e;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ADD = 3'b001,
        OP_LDA = 3'b010,
        OP_STA = 3'b011,
        OP_BUN = 3'b100,
        OP_BSA = 3'b101,
        OP_ISZ = 3'b110,
        OP_REG = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        BUS_NONE = 3'b000,
        BUS_AR   = 3'b001,
        BUS_PC   = 3'b010,
        BUS_DR   = 3'b011,
        BUS_AC   = 3'b100,
        BUS_IR   = 3'b101,
        BUS_RAM  = 3'b111
    } bus_src_e;

    typedef enum logic [1:0] {
        ALU_DR  = 2'b00,
        ALU_AND = 2'b01,
        ALU_ADD = 2'b10
    } alu_op_e;

    t_state_e          state_q, state_d;
    logic              running_q, running_d;

    // Instruction fields. IR only carries the fetched word from T2 onward,
    // so nothing below decodes these before T3 except the T2 address load.
    logic              ind;
    opcode_e           op;
    logic [ADDR_W-1:0] ir_low;
    logic              dr_zero;

    assign ind     = ir[DATA_W-1];
    assign op      = opcode_e'(ir[DATA_W-2 -: 3]);
    assign ir_low  = ir[ADDR_W-1:0];
    assign dr_zero = (dr == '0);

    assign sc      = state_q;
    assign running = running_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= T0;
            running_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            running_q <= running_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case statements can infer a latch.
        state_d   = state_q;
        running_d = running_q;
        bus_sel   = BUS_NONE;
        ld_ar     = 1'b0;
        inc_ar    = 1'b0;
        ld_pc     = 1'b0;
        inc_pc    = 1'b0;
        ld_dr     = 1'b0;
        inc_dr    = 1'b0;
        ld_ir     = 1'b0;
        ld_ac     = 1'b0;
        alu_op    = ALU_DR;
        clr_ac    = 1'b0;
        cma_ac    = 1'b0;
        inc_ac    = 1'b0;
        mem_wr    = 1'b0;

        if (!running_q) begin
            // Idle or halted: all strobes stay low, only start is honoured.
            if (start) begin
                running_d = 1'b1;
                state_d   = T0;
            end
        end else begin
            unique case (state_q)
                // ---------------- fetch / decode ----------------
                T0: begin
                    bus_sel = BUS_PC;
                    ld_ar   = 1'b1;
                    state_d = T1;
                end
                T1: begin
                    bus_sel = BUS_RAM;
                    ld_ir   = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = T2;
                end
                T2: begin
                    bus_sel = BUS_IR;
                    ld_ar   = 1'b1;
                    state_d = T3;
                end
                T3: begin
                    if (op == OP_REG) begin
                        state_d = T0;
                        // I=1 with opcode 111 is illegal and treated as NOP.
                        if (!ind) begin
                            // Several bits may be set at once; the datapath
                            // orders them clr -> cma -> inc.
                            clr_ac = ir_low[3];
                            cma_ac = ir_low[2];
                            inc_ac = ir_low[1];
                            if (ir_low[0]) begin
                                running_d = 1'b0;
                            end
                        end
                    end else begin
                        state_d = T4;
                        if (ind) begin
                            bus_sel = BUS_RAM;
                            ld_ar   = 1'b1;
                        end
                    end
                end
                // ---------------- memory reference execute ----------------
                T4: begin
                    state_d = T0;
                    unique case (op)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            bus_sel = BUS_RAM;
                            ld_dr   = 1'b1;
                            state_d = T5;
                        end
                        OP_STA: begin
                            bus_sel = BUS_AC;
                            mem_wr  = 1'b1;
                        end
                        OP_BUN: begin
                            bus_sel = BUS_AR;
                            ld_pc   = 1'b1;
                        end
                        OP_BSA: begin
                            // Return address goes to M[AR]; AR then points at
                            // the subroutine body, which T5 jumps to.
                            bus_sel = BUS_PC;
                            mem_wr  = 1'b1;
                            inc_ar  = 1'b1;
                            state_d = T5;
                        end
                        default: begin
                            // Register-reference never reaches T4.
                            state_d = T0;
                        end
                    endcase
                end
                T5: begin
                    state_d = T0;
                    unique case (op)
                        OP_AND: begin
                            ld_ac  = 1'b1;
                            alu_op = ALU_AND;
                        end
                        OP_ADD: begin
                            ld_ac  = 1'b1;
                            alu_op = ALU_ADD;
                        end
                        OP_LDA: begin
                            ld_ac  = 1'b1;
                            alu_op = ALU_DR;
                        end
                        OP_BSA: begin
                            bus_sel = BUS_AR;
                            ld_pc   = 1'b1;
                        end
                        OP_ISZ: begin
                            inc_dr  = 1'b1;
                            state_d = T6;
                        end
                        default: begin
                            state_d = T0;
                        end
                    endcase
                end
                T6: begin
                    // Only ISZ reaches T6; DR already holds the incremented
                    // operand, so the skip test looks at it directly.
                    state_d = T0;
                    if (op == OP_ISZ) begin
                        bus_sel = BUS_DR;
                        mem_wr  = 1'b1;
                        inc_pc  = dr_zero;
                    end
                end
                default: begin
                    // Unreachable T7: recover to T0 with no strobes.
                    state_d = T0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mano_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mano_control_sequencer
//
// Scoreboard bench for the Mano control sequencer. The stimulus side builds
// the expected per-cycle output pattern of each instruction from the
// instruction-set rules and queues it; an independent monitor samples the
// DUT on every falling edge and compares against the queue head.
// -----------------------------------------------------------------------------
module tb_mano_control_sequencer;

    typedef struct packed {
        logic [2:0] bus;
        logic       ld_ar;
        logic       inc_ar;
        logic       ld_pc;
        logic       inc_pc;
        logic       ld_dr;
        logic       inc_dr;
        logic       ld_ir;
        logic       ld_ac;
        logic [1:0] alu_op;
        logic       clr;
        logic       cma;
        logic       inc_ac;
        logic       mem_wr;
        logic       run;
        logic [2:0] sc;
    } rec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] ir;
    logic [7:0] dr;
    logic [2:0] bus_sel;
    logic       ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ir, ld_ac;
    logic [1:0] alu_op;
    logic       clr_ac, cma_ac, inc_ac, mem_wr, running;
    logic [2:0] sc;

    int n_tests = 0;
    int n_fail  = 0;

    rec_t exp_q[$];
    rec_t seq[$];
    bit   halted;

    mano_control_sequencer #(
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ir      (ir),
        .dr      (dr),
        .bus_sel (bus_sel),
        .ld_ar   (ld_ar),
        .inc_ar  (inc_ar),
        .ld_pc   (ld_pc),
        .inc_pc  (inc_pc),
        .ld_dr   (ld_dr),
        .inc_dr  (inc_dr),
        .ld_ir   (ld_ir),
        .ld_ac   (ld_ac),
        .alu_op  (alu_op),
        .clr_ac  (clr_ac),
        .cma_ac  (cma_ac),
        .inc_ac  (inc_ac),
        .mem_wr  (mem_wr),
        .running (running),
        .sc      (sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t cur();
        rec_t r;
        r.bus    = bus_sel;
        r.ld_ar  = ld_ar;
        r.inc_ar = inc_ar;
        r.ld_pc  = ld_pc;
        r.inc_pc = inc_pc;
        r.ld_dr  = ld_dr;
        r.inc_dr = inc_dr;
        r.ld_ir  = ld_ir;
        r.ld_ac  = ld_ac;
        r.alu_op = alu_op;
        r.clr    = clr_ac;
        r.cma    = cma_ac;
        r.inc_ac = inc_ac;
        r.mem_wr = mem_wr;
        r.run    = running;
        r.sc     = sc;
        return r;
    endfunction

    function automatic rec_t mk(input int t, input logic [2:0] b);
        rec_t r;
        r     = '0;
        r.run = 1'b1;
        r.sc  = t[2:0];
        r.bus = b;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: expected cycle-by-cycle behaviour of one
    // instruction, written from the instruction-set description.
    // ------------------------------------------------------------------
    task automatic build(input logic [7:0] iv, input logic [7:0] dv, output bit halts);
        rec_t       r;
        logic       i_bit;
        logic [2:0] opc;
        i_bit = iv[7];
        opc   = iv[6:4];
        halts = 1'b0;
        seq.delete();
        // fetch: AR<-PC ; IR<-M[AR], PC++ ; AR<-IR[3:0]
        r = mk(0, 3'b010); r.ld_ar = 1'b1;                  seq.push_back(r);
        r = mk(1, 3'b111); r.ld_ir = 1'b1; r.inc_pc = 1'b1; seq.push_back(r);
        r = mk(2, 3'b101); r.ld_ar = 1'b1;                  seq.push_back(r);
        if (opc == 3'b111) begin
            r = mk(3, 3'b000);
            if (!i_bit) begin
                r.clr    = iv[3];
                r.cma    = iv[2];
                r.inc_ac = iv[1];
                halts    = iv[0];
            end
            seq.push_back(r);
            return;
        end
        r = mk(3, i_bit ? 3'b111 : 3'b000);
        r.ld_ar = i_bit;
        seq.push_back(r);
        case (opc)
            3'd0, 3'd1, 3'd2: begin
                r = mk(4, 3'b111); r.ld_dr = 1'b1; seq.push_back(r);
                r = mk(5, 3'b000); r.ld_ac = 1'b1;
                r.alu_op = (opc == 3'd0) ? 2'b01 : (opc == 3'd1) ? 2'b10 : 2'b00;
                seq.push_back(r);
            end
            3'd3: begin
                r = mk(4, 3'b100); r.mem_wr = 1'b1; seq.push_back(r);
            end
            3'd4: begin
                r = mk(4, 3'b001); r.ld_pc = 1'b1; seq.push_back(r);
            end
            3'd5: begin
                r = mk(4, 3'b010); r.mem_wr = 1'b1; r.inc_ar = 1'b1; seq.push_back(r);
                r = mk(5, 3'b001); r.ld_pc = 1'b1;                   seq.push_back(r);
            end
            default: begin
                r = mk(4, 3'b111); r.ld_dr = 1'b1;  seq.push_back(r);
                r = mk(5, 3'b000); r.inc_dr = 1'b1; seq.push_back(r);
                r = mk(6, 3'b011); r.mem_wr = 1'b1; r.inc_pc = (dv == 8'h00);
                seq.push_back(r);
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Stimulus tasks (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_q.push_back('0);
        end
    endtask

    task automatic start_pulse();
        @(posedge clk); #1;
        start = 1'b1;
        exp_q.push_back('0);
    endtask

    // Runs one instruction (or its first 'limit' cycles when limit > 0).
    // IR carries garbage during T0/T1 and DR carries garbage except at T6,
    // so any early decode of either shows up as a mismatch.
    task automatic run_instr(input logic [7:0] iv, input logic [7:0] dv, input int limit);
        bit h;
        int n;
        build(iv, dv, h);
        n = (limit > 0 && limit < seq.size()) ? limit : seq.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                for (int j = 0; j < n; j++) exp_q.push_back(seq[j]);
            end
            start = 1'($urandom_range(0, 1));   // ignored while running
            ir    = (k < 2) ? 8'($urandom) : iv;
            dr    = (k == 6) ? dv : 8'($urandom);
        end
        halted = h;
    endtask

    task automatic exec(input logic [7:0] iv, input logic [7:0] dv, input int halt_idle);
        run_instr(iv, dv, 0);
        if (halted) begin
            idle_cycles(halt_idle);
            start_pulse();
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one expected record per sampled cycle
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        rec_t e;
        rec_t a;
        if (!rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = cur();
            if (!e.ld_ac) a.alu_op = 2'b00;     // alu_op only matters with ld_ac
            check($sformatf("seq_run%0d_T%0d", e.run, e.sc), {11'b0, a}, {11'b0, e});
        end
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] riv;
        logic [7:0] rdv;
        int         guard;

        rst   = 1'b1;
        start = 1'b0;
        ir    = 8'h00;
        dr    = 8'h00;
        halted = 1'b0;

        #1;
        check("reset_async", {11'b0, cur()}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;                           // start must not act under reset
        @(posedge clk); #1;
        check("reset_hold", {11'b0, cur()}, 32'h0);
        start = 1'b0;
        rst   = 1'b0;

        idle_cycles(3);
        start_pulse();

        // Directed instructions
        exec(8'h05, 8'h00, 0);                  // AND direct
        exec(8'hB3, 8'h00, 0);                  // STA indirect
        exec(8'h6A, 8'h00, 0);                  // ISZ, DR==0 -> skip
        exec(8'h6A, 8'h05, 0);                  // ISZ, DR!=0 -> no skip
        exec(8'h5C, 8'h00, 0);                  // BSA
        exec(8'hF0, 8'h00, 0);                  // illegal reg-ref, NOP
        exec(8'h4E, 8'h00, 0);                  // BUN
        exec(8'h2E, 8'h00, 0);                  // LDA
        exec(8'h7E, 8'h00, 0);                  // CLA+CMA+INC together
        exec(8'h71, 8'h00, 10);                 // HLT, idle 10 cycles, restart

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            riv = 8'($urandom);
            rdv = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
            exec(riv, rdv, 3);
        end

        // Reset in the middle of an ADD (T4): outputs drop at once, ld_ac
        // never appears for the aborted instruction.
        run_instr(8'h17, 8'h00, 5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", {11'b0, cur()}, 32'h0);
        check("abort_ld_ac", {31'b0, ld_ac}, 32'h0);
        @(posedge clk); #1;
        check("abort_hold", {11'b0, cur()}, 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        exp_q.push_back('0);                    // stays idle without start
        idle_cycles(2);
        start_pulse();
        exec(8'h9E, 8'h00, 0);                  // ADD indirect from T0 again
        exec(8'h35, 8'h00, 0);                  // STA direct

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mano_control_sequencer.md
Name: mano_control_sequencer

Overview:
- Timing and control unit of the 8-bit Mano-style computer.
- Runs a 3-bit sequence counter (T0..T6) and decodes IR to produce, each cycle, the common-bus source select (feeds the bus selection mux `s` input) and all register/memory micro-operation strobes.
- Sits directly upstream of the bus mux and the register/ALU datapath. Consumes IR and DR contents from that datapath.

Parameters:
- DATA_W, 8, datapath/bus width (IR, DR).
- ADDR_W, 4, address width (AR, PC, IR[3:0]).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; leaves idle/halt and begins fetch
- ir  in  DATA_W  instruction register: IR[7]=I, IR[6:4]=opcode, IR[3:0]=address/reg-ref bits
- dr  in  DATA_W  data register contents (ISZ zero test)
- bus_sel  out  3  bus source: 000 none, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 111 RAM
- ld_ar, inc_ar, ld_pc, inc_pc, ld_dr, inc_dr, ld_ir, ld_ac  out  1 each  register strobes
- alu_op  out  2  AC source when ld_ac: 00 DR, 01 AC&DR, 10 AC+DR (E gets carry)
- clr_ac, cma_ac, inc_ac  out  1 each  register-reference ops on AC
- mem_wr  out  1  RAM[AR] <= bus at clock edge
- running  out  1  sequencer active
- sc  out  3  current timing state T index

Behaviour:
- Reset (async, immediate): sc=0, running=0. Every output strobe is 0 and bus_sel=000 while rst=1 and whenever running=0.
- Idle/halt: start=1 while running=0 sets running=1 and sc=0 at the next edge. start is ignored while running=1.
- Strobes are decoded combinationally from registered sc/running plus ir/dr. A strobe asserted in Tn takes effect at the edge ending Tn. sc increments every cycle unless "SC<-0" is stated.
- IR is stable from T2 onward and is decoded directly.
- Fetch/decode, all instructions:
  - T0: bus_sel=010, ld_ar.
  - T1: bus_sel=111, ld_ir, inc_pc.
  - T2: bus_sel=101, ld_ar (AR <= IR[3:0]).
- T3:
  - Opcode != 111 and I=1: bus_sel=111, ld_ar (indirect).
  - Opcode != 111 and I=0: no strobes.
  - Opcode 111 and I=0, register reference, SC<-0:
    - IR[3] gives clr_ac.
    - IR[2] gives cma_ac.
    - IR[1] gives inc_ac.
    - IR[0] gives HLT: running <= 0 at the edge.
    - Multiple bits assert their strobes simultaneously; the datapath applies clr, then cma, then inc. IR[3:0]=0000 is a NOP.
  - Opcode 111 and I=1: illegal, NOP, SC<-0.
- Memory reference, T4 onward:
  - 000 AND: T4 bus_sel=111, ld_dr. T5 ld_ac, alu_op=01, SC<-0.
  - 001 ADD: T4 same as AND. T5 ld_ac, alu_op=10, SC<-0.
  - 010 LDA: T4 same as AND. T5 ld_ac, alu_op=00, SC<-0.
  - 011 STA: T4 bus_sel=100, mem_wr, SC<-0.
  - 100 BUN: T4 bus_sel=001, ld_pc, SC<-0.
  - 101 BSA: T4 bus_sel=010, mem_wr, inc_ar. T5 bus_sel=001, ld_pc, SC<-0.
  - 110 ISZ:
    - T4: bus_sel=111, ld_dr.
    - T5: inc_dr.
    - T6: bus_sel=011, mem_wr, inc_pc iff dr==0, SC<-0.
- At most one of ld_* and mem_wr share a bus cycle; bus_sel is never a non-000 value without a consumer strobe.
- sc never exceeds 6. An unreachable state (sc=7) forces SC<-0 with no strobes.
- rst asserted mid-instruction aborts immediately. No partial strobe survives; start is required to resume from T0.

Test Plan:
- Reset then start, ir=8'h05 loaded at T1 (AND, direct) -> the following sequence, then sc=0 at T6:
  - T0 bus_sel=010/ld_ar
  - T1 111/ld_ir/inc_pc
  - T2 101/ld_ar
  - T3 none
  - T4 111/ld_dr
  - T5 ld_ac, alu_op=01
- ir=8'hB3 (I=1, STA) -> T3 bus_sel=111/ld_ar; T4 bus_sel=100, mem_wr=1; next cycle sc=0.
- ir=8'h6A (ISZ): dr=8'h00 at T6 -> inc_pc=1 with mem_wr, bus_sel=011; repeat with dr=8'h05 -> inc_pc=0.
- ir=8'h71 (HLT) -> T3 then running=0, all strobes 0 for 10 cycles; start pulse -> T0 strobes return next cycle.
- ir=8'h5C (BSA) -> T4 bus_sel=010, mem_wr, inc_ar; T5 bus_sel=001, ld_pc. Then ir=8'hF0 -> T3 no strobes, sc=0.
- rst pulsed mid-T4 of ADD -> outputs 0 asynchronously, running=0, sc=0; no ld_ac ever asserted for that instruction.
